// File: rtl/wb_exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_exc_ctrl_pkg
// Shared CP0 definitions for the WB-boundary exception controller:
//   - ExcCode constants latched into Cause.ExcCode
//   - CP0 register selects, encoded as {rd[4:0], sel[2:0]}
//   - default exception vector (Status.BEV fixed at 1)
//   - controller state encoding and the EPC helper
// -----------------------------------------------------------------------------
package wb_exc_ctrl_pkg;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // CP0 register selects {rd, sel}
    localparam logic [7:0] CR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

    // Exception vector with BEV = 1
    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hbfc00380;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } wbx_state_e;

    // EPC points at the branch when the faulting instruction is in its delay slot.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/wb_exc_ctrl_int_sync2.sv
// -----------------------------------------------------------------------------
// wb_exc_ctrl_int_sync2
// Two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears both stages
//   d_i    - asynchronous input bus (bits are treated independently)
//   q_o    - synchronized output, two cycles after an input edge
// -----------------------------------------------------------------------------
module wb_exc_ctrl_int_sync2 #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/wb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// wb_exc_ctrl
// Initiator side of the CP0 exception / MTC0 interface at the WB boundary.
// Picks at most one CP0 event per cycle (exception entry, ERET, MTC0 write),
// drives the CP0 strobes and the pipeline flush, then holds off further
// events for FLUSH_HOLD cycles while the pipeline drains.
//
// Handshake: there is no back-pressure. An event is taken in the same cycle
// that ws_valid is high while IDLE; CP0 latches the strobes/data at the next
// edge. While HOLD, ws_block is high and the WB instruction is discarded.
//
// Ports:
//   clk, reset                         clock, async active-high reset
//   ws_*                               WB-stage instruction status
//   hw_int                             asynchronous interrupt lines
//   cp0_status_*, cp0_cause_ip_sw,
//   cp0_epc                            current CP0 state
//   cp0_hw_ip                          synchronized interrupts to Cause.IP[7:2]
//   wb_ex, wb_excode, wb_epc, wb_bd,
//   wb_badvaddr                        exception entry strobe + data
//   eret_flush                         ERET strobe
//   mtc0_we, cp0_addr, cp0_wdata       CP0 register write
//   flush, flush_pc                    pipeline flush and redirect target
//   ws_block                           WB commit suppressed (HOLD)
//   dbg_state                          controller state, for observation
// -----------------------------------------------------------------------------
module wb_exc_ctrl
    import wb_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY   = EX_ENTRY_DEFAULT,
    parameter int          FLUSH_HOLD = 2,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ws_valid,
    input  logic                ws_ex,
    input  logic [4:0]          ws_excode,
    input  logic [31:0]         ws_pc,
    input  logic                ws_bd,
    input  logic [31:0]         ws_badvaddr,
    input  logic                ws_eret,
    input  logic                ws_mtc0,
    input  logic [7:0]          ws_cp0_addr,
    input  logic [31:0]         ws_wdata,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                cp0_status_ie,
    input  logic                cp0_status_exl,
    input  logic [7:0]          cp0_status_im,
    input  logic [1:0]          cp0_cause_ip_sw,
    input  logic [31:0]         cp0_epc,
    output logic [HW_INT_W-1:0] cp0_hw_ip,
    output logic                wb_ex,
    output logic [4:0]          wb_excode,
    output logic [31:0]         wb_epc,
    output logic                wb_bd,
    output logic [31:0]         wb_badvaddr,
    output logic                eret_flush,
    output logic                mtc0_we,
    output logic [7:0]          cp0_addr,
    output logic [31:0]         cp0_wdata,
    output logic                flush,
    output logic [31:0]         flush_pc,
    output logic                ws_block,
    output wbx_state_e          dbg_state
);

    localparam logic [2:0] HOLD_LOAD = 3'(FLUSH_HOLD - 1);

    wbx_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       int_pend;
    logic       take;
    logic [7:0] ip_all;

    // ------------------------------------------------------------------
    // Interrupt synchronizer and pending detection
    // ------------------------------------------------------------------
    wb_exc_ctrl_int_sync2 #(
        .W (HW_INT_W)
    ) u_int_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (hw_int),
        .q_o   (cp0_hw_ip)
    );

    // Cause.IP[7:0] = {hardware lines, software bits}
    assign ip_all   = 8'({cp0_hw_ip, cp0_cause_ip_sw});
    assign int_pend = cp0_status_ie & ~cp0_status_exl & (|(cp0_status_im & ip_all));

    // ------------------------------------------------------------------
    // Event selection (same-cycle). Gated by reset so every strobe and
    // data output reads 0 while reset is held, even though state is IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        take        = ~reset & (state_q == ST_IDLE) & ws_valid;
        wb_ex       = 1'b0;
        wb_excode   = 5'h00;
        wb_epc      = 32'h0;
        wb_bd       = 1'b0;
        wb_badvaddr = 32'h0;
        eret_flush  = 1'b0;
        mtc0_we     = 1'b0;
        cp0_addr    = 8'h00;
        cp0_wdata   = 32'h0;
        flush       = 1'b0;
        flush_pc    = 32'h0;

        // Fixed priority; lower-priority requests in the same cycle are dropped.
        if (take) begin
            if (int_pend) begin
                wb_ex     = 1'b1;
                wb_excode = EXC_INT;
            end else if (ws_ex) begin
                wb_ex     = 1'b1;
                wb_excode = ws_excode;
            end else if (ws_eret) begin
                eret_flush = 1'b1;
            end else if (ws_mtc0) begin
                mtc0_we = 1'b1;
            end
        end

        if (wb_ex) begin
            wb_epc      = calc_epc(ws_pc, ws_bd);
            wb_bd       = ws_bd;
            wb_badvaddr = ws_badvaddr;
            flush_pc    = EX_ENTRY;
        end
        if (eret_flush) begin
            flush_pc = cp0_epc;
        end
        if (mtc0_we) begin
            cp0_addr  = ws_cp0_addr;
            cp0_wdata = ws_wdata;
        end
        flush = wb_ex | eret_flush;
    end

    // ------------------------------------------------------------------
    // Hold-window FSM. Counter loads FLUSH_HOLD-1 on entry and HOLD exits
    // on the cycle it reads 0, giving exactly FLUSH_HOLD HOLD cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ws_block  = (state_q == ST_HOLD);
    assign dbg_state = state_q;

endmodule
